// File: rtl/link_pkg.sv
// Shared frame encodings and controller state set for the serial arbitration link.
package link_pkg;

    localparam logic       FRAME_START = 1'b1;

    // Uplink payloads (master -> arbiter port)
    localparam logic [1:0] UP_REQ      = 2'b11;
    localparam logic [1:0] UP_ACK      = 2'b01;
    localparam logic [1:0] UP_NAK      = 2'b10;
    localparam logic [1:0] UP_END      = 2'b00;

    // Downlink payloads (arbiter port -> master)
    localparam logic [1:0] DN_GRANT    = 2'b11;
    localparam logic [1:0] DN_RESUME   = 2'b10;
    localparam logic [1:0] DN_SPLIT    = 2'b01;
    localparam logic [1:0] DN_PREEMPT  = 2'b00;

    typedef enum logic [3:0] {
        IDLE,
        SEND_REQ,
        WAIT_GRANT,
        SEND_ACK,
        SEND_NAK,
        COM,
        SEND_END,
        SEND_STOP,
        WAIT_RESUME
    } state_t;

endpackage

// File: rtl/link_tx_shifter.sv
// Parallel-load, MSB-first serialiser; frames shorter than W sit left-aligned with zero fill.
module link_tx_shifter #(
    parameter int W  = 5,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          load,
    input  logic [W-1:0]  data,
    input  logic [LW-1:0] len,
    output logic          dout,
    output logic          busy
);

    logic [W-1:0]  sr;
    logic [LW-1:0] cnt;

    // A load while a frame is still in flight is dropped rather than truncating it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load && cnt == '0) begin
            sr  <= data;
            cnt <= len;
        end else if (cnt != '0) begin
            sr  <= {sr[W-2:0], 1'b0};
            cnt <= cnt - 1'b1;
        end
    end

    assign dout = sr[W-1];
    assign busy = (cnt != '0);

endmodule

// File: rtl/master_link_ctrl.sv
// Master-side link controller: frames bus requests, decodes grant/resume/split/preempt, answers ACK/NAK.
module master_link_ctrl
    import link_pkg::*;
#(
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] req_id,
    input  logic                  ready,
    input  logic                  done,
    input  logic                  link_in,
    output logic                  link_out,
    output logic                  bus_owned,
    output logic                  split,
    output logic                  preempted,
    output logic                  refused,
    output logic [S_ID_WIDTH-1:0] held_id
);

    localparam int W         = 3 + S_ID_WIDTH;
    localparam int LW        = $clog2(W + 1);
    localparam int RX_STAGES = 1;

    localparam logic [W-1:0] ACK_FRAME = {FRAME_START, UP_ACK, {S_ID_WIDTH{1'b0}}};
    localparam logic [W-1:0] NAK_FRAME = {FRAME_START, UP_NAK, {S_ID_WIDTH{1'b0}}};
    localparam logic [W-1:0] END_FRAME = {FRAME_START, UP_END, {S_ID_WIDTH{1'b0}}};

    // ---------------- rx framer ----------------
    logic [1:0]           rx_cnt;
    logic [1:0]           rx_sh;
    logic [1:0]           dl_code;
    logic [RX_STAGES:0]   vld_pipe;
    logic                 dl_vld;

    // Capture stage then one decode register, so a response starts two cycles after the last bit.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_cnt   <= '0;
            rx_sh    <= '0;
            dl_code  <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= 1'b0;
            if (rx_cnt == '0) begin
                if (link_in) rx_cnt <= 2'd2;
            end else begin
                rx_sh  <= {rx_sh[0], link_in};
                rx_cnt <= rx_cnt - 1'b1;
                if (rx_cnt == 2'd1) vld_pipe[0] <= 1'b1;
            end
            vld_pipe[RX_STAGES:1] <= vld_pipe[RX_STAGES-1:0];
            if (vld_pipe[0]) dl_code <= rx_sh;
        end
    end

    assign dl_vld = vld_pipe[RX_STAGES];

    // ---------------- tx ----------------
    logic          tx_load;
    logic [W-1:0]  tx_data;
    logic [LW-1:0] tx_len;
    logic          tx_busy;

    link_tx_shifter #(.W(W), .LW(LW)) u_tx (
        .clk  (clk),
        .rstN (rstN),
        .load (tx_load),
        .data (tx_data),
        .len  (tx_len),
        .dout (link_out),
        .busy (tx_busy)
    );

    // ---------------- FSM ----------------
    state_t                state, state_n;
    logic [S_ID_WIDTH-1:0] held_n;
    logic                  owned_n, split_n, pre_n, ref_n, grant_hit;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            held_id   <= '0;
            bus_owned <= 1'b0;
            split     <= 1'b0;
            preempted <= 1'b0;
            refused   <= 1'b0;
        end else begin
            state     <= state_n;
            held_id   <= held_n;
            bus_owned <= owned_n;
            split     <= split_n;
            preempted <= pre_n;
            refused   <= ref_n;
        end
    end

    always_comb begin
        state_n   = state;
        held_n    = held_id;
        owned_n   = bus_owned;
        split_n   = 1'b0;
        pre_n     = 1'b0;
        ref_n     = 1'b0;
        tx_load   = 1'b0;
        tx_data   = END_FRAME;
        tx_len    = LW'(3);
        grant_hit = dl_vld && ((state == WAIT_GRANT  && dl_code == DN_GRANT) ||
                               (state == WAIT_RESUME && dl_code == DN_RESUME));
        case (state)
            IDLE: if (req && req_id != '0) begin
                held_n  = req_id;
                tx_load = 1'b1;
                tx_data = {FRAME_START, UP_REQ, req_id};
                tx_len  = LW'(W);
                state_n = SEND_REQ;
            end
            SEND_REQ:  if (!tx_busy) state_n = WAIT_GRANT;
            SEND_ACK:  if (!tx_busy) begin
                owned_n = 1'b1;
                state_n = COM;
            end
            SEND_NAK, SEND_END: if (!tx_busy) begin
                held_n  = '0;
                state_n = IDLE;
            end
            SEND_STOP: if (!tx_busy) state_n = WAIT_RESUME;
            // done outranks a split/preempt decoded in the same cycle
            COM: if (done) begin
                tx_load = 1'b1;
                owned_n = 1'b0;
                state_n = SEND_END;
            end else if (dl_vld && dl_code == DN_SPLIT) begin
                tx_load = 1'b1;
                owned_n = 1'b0;
                split_n = 1'b1;
                state_n = SEND_STOP;
            end else if (dl_vld && dl_code == DN_PREEMPT) begin
                tx_load = 1'b1;
                owned_n = 1'b0;
                pre_n   = 1'b1;
                state_n = SEND_END;
            end
            default: ;
        endcase
        if (grant_hit) begin
            tx_load = 1'b1;
            tx_data = ready ? ACK_FRAME : NAK_FRAME;
            ref_n   = !ready;
            state_n = ready ? SEND_ACK : SEND_NAK;
        end
    end

endmodule

// File: tb/tb_master_link_ctrl.sv
// Directed bench for master_link_ctrl: request/grant handshakes, split/resume, preempt, NAK, reset.
module tb_master_link_ctrl;

    logic       clk = 1'b0;
    logic       rstN, req, ready, done, link_in;
    logic [1:0] req_id;
    logic       link_out, bus_owned, split, preempted, refused;
    logic [1:0] held_id;

    int n_cmp = 0, n_bad = 0;
    int split_cnt = 0, pre_cnt = 0, ref_cnt = 0;

    master_link_ctrl #(.NO_SLAVES(3)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .req       (req),
        .req_id    (req_id),
        .ready     (ready),
        .done      (done),
        .link_in   (link_in),
        .link_out  (link_out),
        .bus_owned (bus_owned),
        .split     (split),
        .preempted (preempted),
        .refused   (refused),
        .held_id   (held_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (split)     split_cnt++;
        if (preempted) pre_cnt++;
        if (refused)   ref_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // start bit + 2 payload bits; returns just after the edge sampling the last bit
    task automatic send_dl(input logic [1:0] code);
        link_in = 1'b1;    tick();
        link_in = code[1]; tick();
        link_in = code[0]; tick();
        link_in = 1'b0;
    endtask

    task automatic recv_frame(input string tag, input int n, input logic [7:0] exp);
        for (int i = 0; i < n; i++) begin
            chk(tag, link_out, exp[n-1-i]);
            tick();
        end
    endtask

    task automatic do_request(input logic [1:0] id);
        req = 1'b1; req_id = id;
        tick();
        req = 1'b0;
        chk("held_latch", held_id, id);
        recv_frame("req_frame", 5, {3'b0, 3'b111, id});
        tick();
    endtask

    task automatic respond_ack(input logic [1:0] code);
        ready = 1'b1;
        send_dl(code);
        tick(); tick();
        recv_frame("ack_frame", 3, 8'b101);
        chk("owned_lo", bus_owned, 0);
        tick();
        chk("owned_hi", bus_owned, 1);
    endtask

    task automatic idle_no_response(input string tag);
        int ones;
        ones = 0;
        ready = 1'b1;
        send_dl(2'b11);
        repeat (6) begin
            tick();
            ones += int'(link_out);
        end
        chk(tag, ones, 0);
    endtask

    initial begin
        rstN = 1'b0; req = 1'b0; req_id = 2'd0; ready = 1'b1; done = 1'b0; link_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_link_out", link_out, 0);
        chk("rst_owned", bus_owned, 0);
        chk("rst_split", split, 0);
        chk("rst_preempt", preempted, 0);
        chk("rst_refused", refused, 0);
        chk("rst_held", held_id, 0);
        rstN = 1'b1;
        tick();

        // req with id 0 is ignored
        req = 1'b1; req_id = 2'd0;
        tick(); tick();
        chk("id0_link", link_out, 0);
        chk("id0_held", held_id, 0);
        req = 1'b0;
        tick();

        // request slave 2, granted and acknowledged
        do_request(2'd2);
        respond_ack(2'b11);

        // split in COM, then resume
        send_dl(2'b01);
        tick(); tick();
        chk("split_pulse", split, 1);
        chk("split_owned", bus_owned, 0);
        recv_frame("stop_frame", 3, 8'b100);
        chk("split_held", held_id, 2);
        chk("split_cnt", split_cnt, 1);
        tick();
        respond_ack(2'b10);

        // preempt in COM
        send_dl(2'b00);
        tick(); tick();
        chk("pre_pulse", preempted, 1);
        chk("pre_owned", bus_owned, 0);
        recv_frame("pre_end", 3, 8'b100);
        tick();
        chk("pre_held", held_id, 0);
        chk("pre_cnt", pre_cnt, 1);

        // grant with ready low -> NAK
        do_request(2'd2);
        ready = 1'b0;
        send_dl(2'b11);
        tick(); tick();
        chk("nak_refused", refused, 1);
        recv_frame("nak_frame", 3, 8'b110);
        tick();
        chk("nak_held", held_id, 0);
        chk("nak_owned", bus_owned, 0);
        chk("ref_cnt", ref_cnt, 1);
        ready = 1'b1;

        // done coincident with split decode: done wins
        do_request(2'd1);
        respond_ack(2'b11);
        send_dl(2'b01);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("dn_split", split, 0);
        chk("dn_owned", bus_owned, 0);
        recv_frame("dn_end", 3, 8'b100);
        tick();
        chk("dn_held", held_id, 0);
        chk("dn_split_cnt", split_cnt, 1);
        idle_no_response("dn_idle_grant");

        // reset in the middle of a REQ frame
        tick();
        req = 1'b1; req_id = 2'd3;
        tick();
        req = 1'b0;
        tick(); tick();
        chk("pre_rst_link", link_out, 1);
        rstN = 1'b0;
        #1;
        chk("mid_rst_link", link_out, 0);
        chk("mid_rst_held", held_id, 0);
        chk("mid_rst_owned", bus_owned, 0);
        tick();
        rstN = 1'b1;
        tick();
        idle_no_response("rst_idle_grant");
        chk("rst_idle_held", held_id, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
